// File: rtl/ibniz_pkg.sv
// Shared definitions for the Ibniz video blocks.
//   - Y'UV -> RGB coefficients (20-bit signed so products stay in range)
//   - fade FSM state encoding
//   - bit positions of the bright / hue1 / hue2 fields in a generator word
package ibniz_pkg;

  localparam logic signed [19:0] YUV_K_C  = 20'sd298;
  localparam logic signed [19:0] YUV_K_RD = 20'sd516;
  localparam logic signed [19:0] YUV_K_GD = 20'sd100;
  localparam logic signed [19:0] YUV_K_GE = 20'sd208;
  localparam logic signed [19:0] YUV_K_BE = 20'sd409;
  localparam logic signed [19:0] YUV_RND  = 20'sd128;

  localparam int HUE1_LSB   = 24;
  localparam int HUE2_LSB   = 16;
  localparam int BRIGHT_LSB = 8;

  typedef enum logic {IDLE, FADE} fade_state_t;

endpackage

// File: rtl/ibniz_yuv2rgb.sv
// One registered Y'UV -> RGB conversion stage.
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset, clears the RGB registers
//   c        brightness, unsigned 8 bit
//   d, e     hue1 / hue2, signed 8 bit
//   r, g, b  clamped 8-bit colour channels, registered
module ibniz_yuv2rgb (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        c,
  input  logic signed [7:0] d,
  input  logic signed [7:0] e,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);
  import ibniz_pkg::*;

  logic signed [19:0] c20, d20, e20;
  logic signed [19:0] r_acc, g_acc, b_acc;

  // Worst case magnitude is ~142k, well inside 20-bit signed range.
  assign c20 = {12'd0, c};
  assign d20 = {{12{d[7]}}, d};
  assign e20 = {{12{e[7]}}, e};

  assign r_acc = YUV_K_C * c20 + YUV_K_RD * d20 + YUV_RND;
  assign g_acc = YUV_K_C * c20 - YUV_K_GD * d20 - YUV_K_GE * e20 + YUV_RND;
  assign b_acc = YUV_K_C * c20 + YUV_K_BE * e20 + YUV_RND;

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    logic signed [19:0] s;
    s = v >>> 8;
    if (s < 20'sd0)        return 8'd0;
    else if (s > 20'sd255) return 8'hFF;
    else                   return s[7:0];
  endfunction

  // ---- stage 3: clamp and register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= 8'd0;
      g <= 8'd0;
      b <= 8'd0;
    end else begin
      r <= clamp8(r_acc);
      g <= clamp8(g_acc);
      b <= clamp8(b_acc);
    end
  end

endmodule

// File: rtl/ibniz_scene_mixer.sv
// Ibniz scene mixer: coordinate/time front-end for N_SCENES generators,
// run-time scene selection with a frame-driven cross-fade, and a 3-stage
// Y'UV -> RGB pipeline toward the VGA output.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   iX_video, iY_video   signed pixel position from the timing generator
//   endFrame             one-cycle end-of-frame strobe
//   scene_req            requested scene index
//   pause, speed         freeze / per-frame increment of the T counter
//   T_out, X_out, Y_out  generator inputs (T = {frame_cnt,16'h0})
//   v_in                 flattened generator words, scene i at [32i+31:32i]
//   oR/oG/oB_video       clamped RGB, 3 clocks after v_in
//   scene_cur, busy      active scene, fade in progress
//   frame_cnt            frame counter
module ibniz_scene_mixer #(
  parameter int N_SCENES   = 8,
  parameter int SEL_W      = 3,
  parameter int RES_X      = 1240,
  parameter int RES_Y      = 1024,
  parameter int XY_STEP    = 7,
  parameter int FADE_SHIFT = 4,
  parameter int INIT_SCENE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [11:0]      iX_video,
  input  logic signed [11:0]      iY_video,
  input  logic                    endFrame,
  input  logic [SEL_W-1:0]        scene_req,
  input  logic                    pause,
  input  logic [3:0]              speed,
  output logic [31:0]             T_out,
  output logic [31:0]             X_out,
  output logic [31:0]             Y_out,
  input  logic [32*N_SCENES-1:0]  v_in,
  output logic [7:0]              oR_video,
  output logic [7:0]              oG_video,
  output logic [7:0]              oB_video,
  output logic [SEL_W-1:0]        scene_cur,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);
  import ibniz_pkg::*;

  localparam int FADE_FRAMES = 1 << FADE_SHIFT;
  localparam int BW          = 11 + FADE_SHIFT;
  localparam logic signed [11:0] CX = 12'(RES_X / 2);
  localparam logic signed [11:0] CY = 12'(RES_Y / 2);

  // Coordinates: the 12-bit difference wraps before sign extension.
  logic signed [11:0] dx, dy;
  logic signed [31:0] dx_ext, dy_ext;

  assign dx     = iX_video - CX;
  assign dy     = iY_video - CY;
  assign dx_ext = {{20{dx[11]}}, dx};
  assign dy_ext = {{20{dy[11]}}, dy};
  assign X_out  = dx_ext <<< XY_STEP;
  assign Y_out  = dy_ext <<< XY_STEP;
  assign T_out  = {frame_cnt, 16'h0};

  // Fade FSM and frame counter
  fade_state_t             state, state_d;
  logic [FADE_SHIFT-1:0]   k, k_d;
  logic [SEL_W-1:0]        scene_nxt, scene_nxt_d, scene_cur_d;
  logic                    req_ok;

  assign req_ok = ({1'b0, scene_req} < (SEL_W+1)'(N_SCENES));

  always_comb begin
    state_d     = state;
    k_d         = k;
    scene_nxt_d = scene_nxt;
    scene_cur_d = scene_cur;
    if (endFrame) begin
      case (state)
        IDLE: begin
          if (scene_req != scene_cur && req_ok) begin
            scene_nxt_d = scene_req;
            k_d         = FADE_SHIFT'(1);
            state_d     = FADE;
          end
        end
        FADE: begin
          if (k == '1) begin
            scene_cur_d = scene_nxt;
            k_d         = '0;
            state_d     = IDLE;
          end else begin
            k_d = k + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      scene_cur <= SEL_W'(INIT_SCENE);
      scene_nxt <= SEL_W'(INIT_SCENE);
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      scene_cur <= scene_cur_d;
      scene_nxt <= scene_nxt_d;
      busy      <= (state_d == FADE);
      if (endFrame && !pause)
        frame_cnt <= frame_cnt + 16'(speed);
    end
  end

  // Scene word selection
  logic [31:0] word_a, word_b;

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < N_SCENES; i++) begin
      if (scene_cur == SEL_W'(i)) word_a = v_in[32*i +: 32];
      if (scene_nxt == SEL_W'(i)) word_b = v_in[32*i +: 32];
    end
  end

  // Weighted mix (a*(F-k) + b*k) >>> FADE_SHIFT; with k == 0 this is a exactly.
  function automatic logic [7:0] blend(input logic signed [9:0] a,
                                       input logic signed [9:0] b,
                                       input logic [FADE_SHIFT-1:0] kw);
    logic signed [BW-1:0] wa, wb, acc;
    wb  = BW'(kw);
    wa  = BW'(FADE_FRAMES) - wb;
    acc = BW'(a) * wa + BW'(b) * wb;
    return 8'(acc >>> FADE_SHIFT);
  endfunction

  // ---- stage 1: capture both scene words and the fade weight ----
  logic [31:0]           a_p1, b_p1;
  logic [FADE_SHIFT-1:0] k_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_p1 <= '0;
      b_p1 <= '0;
      k_p1 <= '0;
    end else begin
      a_p1 <= word_a;
      b_p1 <= word_b;
      k_p1 <= k;
    end
  end

  // Low byte of the generator word carries nothing for the mixer.
  logic unused_lsbs;
  assign unused_lsbs = ^{a_p1[7:0], b_p1[7:0]};

  // ---- stage 2: blend bright (unsigned) and hues (signed) ----
  logic [7:0]        c_p2;
  logic signed [7:0] d_p2, e_p2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_p2 <= '0;
      d_p2 <= '0;
      e_p2 <= '0;
    end else begin
      c_p2 <= blend({2'b00, a_p1[BRIGHT_LSB +: 8]},
                    {2'b00, b_p1[BRIGHT_LSB +: 8]}, k_p1);
      d_p2 <= blend({{2{a_p1[HUE1_LSB+7]}}, a_p1[HUE1_LSB +: 8]},
                    {{2{b_p1[HUE1_LSB+7]}}, b_p1[HUE1_LSB +: 8]}, k_p1);
      e_p2 <= blend({{2{a_p1[HUE2_LSB+7]}}, a_p1[HUE2_LSB +: 8]},
                    {{2{b_p1[HUE2_LSB+7]}}, b_p1[HUE2_LSB +: 8]}, k_p1);
    end
  end

  // ---- stage 3: colour conversion ----
  ibniz_yuv2rgb u_yuv2rgb (
    .clk (clk),
    .rst (rst),
    .c   (c_p2),
    .d   (d_p2),
    .e   (e_p2),
    .r   (oR_video),
    .g   (oG_video),
    .b   (oB_video)
  );

endmodule

// File: tb/tb_ibniz_scene_mixer.sv
module tb_ibniz_scene_mixer;
  localparam int N_SCENES = 8;
  localparam int SEL_W    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [11:0]     iX_video, iY_video;
  logic                   endFrame;
  logic [SEL_W-1:0]       scene_req;
  logic                   pause;
  logic [3:0]             speed;
  logic [31:0]            T_out, X_out, Y_out;
  logic [32*N_SCENES-1:0] v_in;
  logic [7:0]             oR_video, oG_video, oB_video;
  logic [SEL_W-1:0]       scene_cur;
  logic                   busy;
  logic [15:0]            frame_cnt;

  ibniz_scene_mixer #(
    .N_SCENES(N_SCENES), .SEL_W(SEL_W), .RES_X(1240), .RES_Y(1024),
    .XY_STEP(7), .FADE_SHIFT(2), .INIT_SCENE(2)
  ) dut (
    .clk(clk), .rst(rst), .iX_video(iX_video), .iY_video(iY_video),
    .endFrame(endFrame), .scene_req(scene_req), .pause(pause), .speed(speed),
    .T_out(T_out), .X_out(X_out), .Y_out(Y_out), .v_in(v_in),
    .oR_video(oR_video), .oG_video(oG_video), .oB_video(oB_video),
    .scene_cur(scene_cur), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t       sb_q[$];
  logic       issue = 1'b0;
  logic [2:0] tag   = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected RGB leaves the scoreboard three clocks after its vector was issued.
  always @(posedge clk) tag <= {tag[1:0], issue};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (tag[2]) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: output presented with no expected entry");
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_R"}, 32'(oR_video), 32'(e.r));
        check({e.name, "_G"}, 32'(oG_video), 32'(e.g));
        check({e.name, "_B"}, 32'(oB_video), 32'(e.b));
      end
    end
  end

  task automatic expect_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    exp_t e;
    e.name = name; e.r = r; e.g = g; e.b = b;
    sb_q.push_back(e);
    issue = 1'b1;
    @(negedge clk);
    issue = 1'b0;
  endtask

  task automatic pulse_ef();
    endFrame = 1'b1;
    @(negedge clk);
    endFrame = 1'b0;
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    v_in[32*idx +: 32] = w;
  endtask

  initial begin
    int fc;
    rst       = 1'b0;
    endFrame  = 1'b1;
    speed     = 4'd5;
    pause     = 1'b0;
    scene_req = 4'd2;
    iX_video  = 12'sd620;
    iY_video  = 12'sd512;
    v_in      = '0;
    set_word(2, 32'h0000_8000);

    // Reset dominates a live endFrame
    repeat (3) @(negedge clk);
    check("rst_R", 32'(oR_video), 32'd0);
    check("rst_G", 32'(oG_video), 32'd0);
    check("rst_B", 32'(oB_video), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_scene_cur", 32'(scene_cur), 32'd2);
    endFrame = 1'b0;
    speed    = 4'd0;
    rst      = 1'b1;
    @(negedge clk);

    // Coordinates
    check("x_centre", X_out, 32'h0000_0000);
    check("y_centre", Y_out, 32'h0000_0000);
    check("t_zero", T_out, 32'h0000_0000);
    iX_video = 12'sd621; #1;
    check("x_plus1", X_out, 32'h0000_0080);
    iX_video = 12'sd619; #1;
    check("x_minus1", X_out, 32'hFFFF_FF80);
    iY_video = 12'sd0; #1;
    check("y_top", Y_out, 32'hFFFF_0000);
    iX_video = 12'sh800; #1;
    check("x_wrap", X_out, 32'h0002_CA00);
    @(negedge clk);

    // Colour conversion on the steady scene
    repeat (3) @(negedge clk);
    expect_rgb("grey", 8'd149, 8'd149, 8'd149);
    repeat (3) @(negedge clk);
    set_word(2, 32'h7F00_FF00);
    expect_rgb("sat", 8'd255, 8'd247, 8'd255);
    repeat (3) @(negedge clk);
    set_word(2, 32'h8000_0000);
    expect_rgb("neg_hue", 8'd0, 8'd50, 8'd0);
    @(negedge clk);
    check("latency_hold_G", 32'(oG_video), 32'd247);
    repeat (2) @(negedge clk);

    // Cross-fade 2 -> 1 over four frames
    set_word(2, 32'h0000_0000);
    set_word(1, 32'h0000_F000);
    set_word(3, 32'h7F00_FF00);
    repeat (4) @(negedge clk);
    scene_req = 4'd1;
    pulse_ef();
    check("fade_busy", 32'(busy), 32'd1);
    check("fade_cur_hold", 32'(scene_cur), 32'd2);
    expect_rgb("fade_k1", 8'd70, 8'd70, 8'd70);
    repeat (3) @(negedge clk);
    scene_req = 4'd3;
    pulse_ef();
    expect_rgb("fade_k2", 8'd140, 8'd140, 8'd140);
    repeat (3) @(negedge clk);
    pulse_ef();
    check("fade_busy_k3", 32'(busy), 32'd1);
    expect_rgb("fade_k3", 8'd210, 8'd210, 8'd210);
    repeat (3) @(negedge clk);
    scene_req = 4'd9;
    pulse_ef();
    check("fade_done_cur", 32'(scene_cur), 32'd1);
    check("fade_done_busy", 32'(busy), 32'd0);
    expect_rgb("fade_done", 8'd255, 8'd255, 8'd255);
    repeat (3) @(negedge clk);
    pulse_ef();
    check("oor_busy", 32'(busy), 32'd0);
    check("oor_cur", 32'(scene_cur), 32'd1);
    check("speed0_hold", 32'(frame_cnt), 32'd0);

    // Frame counter
    scene_req = 4'd1;
    speed     = 4'd3;
    pulse_ef();
    check("fc_step1", 32'(frame_cnt), 32'd3);
    pulse_ef();
    check("fc_step2", 32'(frame_cnt), 32'd6);
    check("t_out", T_out, 32'h0006_0000);
    fc = 6;
    endFrame = 1'b1;
    speed    = 4'd15;
    while (32'hFFFE - fc >= 15) begin
      @(negedge clk);
      fc += 15;
    end
    if (fc != 32'hFFFE) begin
      speed = 4'(32'hFFFE - fc);
      @(negedge clk);
    end
    endFrame = 1'b0;
    check("fc_preload", 32'(frame_cnt), 32'h0000_FFFE);
    speed = 4'd3;
    pulse_ef();
    check("fc_wrap", 32'(frame_cnt), 32'd1);
    pause = 1'b1;
    pulse_ef();
    check("fc_pause", 32'(frame_cnt), 32'd1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
